// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the parking-system button front end.
package button_conditioner_pkg;

  localparam int unsigned DEF_NUM_CH        = 4;
  localparam int unsigned DEF_STABLE_CYCLES = 50000;
  localparam int unsigned DEF_LONG_CYCLES   = 2000000;
  localparam int unsigned DEF_ACTIVE_LOW    = 1;

  // Per-channel debounce/hold state.
  typedef enum logic [2:0] {
    ST_RELEASED     = 3'd0,
    ST_PRESS_PEND   = 3'd1,
    ST_PRESSED      = 3'd2,
    ST_LONG_HELD    = 3'd3,
    ST_RELEASE_PEND = 3'd4
  } btn_state_e;

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One button channel: synchronizer, stability counter, hold counter, event FSM.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned ACTIVE_LOW    = DEF_ACTIVE_LOW
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned HW = $clog2(LONG_CYCLES + 1);
  // Raw level of an untouched button; also the synchronizer reset value.
  localparam logic RAW_IDLE = logic'(ACTIVE_LOW != 0);

  logic          sync1_q, sync2_q;
  logic [SW-1:0] stab_q, stab_d;
  logic [HW-1:0] hold_q, hold_d;
  btn_state_e    state_q, state_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;

  logic pressed_c, differ_c, accept_c, long_evt_c, hold_full_c;

  // Two-flop synchronizer for the asynchronous raw input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= RAW_IDLE;
      sync2_q <= RAW_IDLE;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Stability and hold counters, both saturating.
  always_comb begin
    pressed_c  = sync2_q ^ RAW_IDLE;
    differ_c   = pressed_c != level_q;
    accept_c   = differ_c && (stab_q == SW'(STABLE_CYCLES - 1));
    stab_d     = '0;
    if (differ_c && !accept_c) begin
      stab_d = (stab_q == SW'(STABLE_CYCLES)) ? stab_q : stab_q + SW'(1);
    end
    hold_d = '0;
    if (level_q) begin
      hold_d = (hold_q == HW'(LONG_CYCLES)) ? hold_q : hold_q + HW'(1);
    end
    long_evt_c  = level_q && (hold_q == HW'(LONG_CYCLES - 1));
    hold_full_c = hold_d == HW'(LONG_CYCLES);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_RELEASED;
    else          state_q <= state_d;
  end

  // FSM next-state logic; a cancelled release returns to the held state it came from.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RELEASED:     if (differ_c) state_d = ST_PRESS_PEND;
      ST_PRESS_PEND: begin
        if (accept_c)       state_d = ST_PRESSED;
        else if (!differ_c) state_d = ST_RELEASED;
      end
      ST_PRESSED: begin
        if (differ_c)        state_d = ST_RELEASE_PEND;
        else if (long_evt_c) state_d = ST_LONG_HELD;
      end
      ST_LONG_HELD:    if (differ_c) state_d = ST_RELEASE_PEND;
      ST_RELEASE_PEND: begin
        if (accept_c)       state_d = ST_RELEASED;
        else if (!differ_c) state_d = hold_full_c ? ST_LONG_HELD : ST_PRESSED;
      end
      default:         state_d = ST_RELEASED;
    endcase
  end

  // FSM output logic: next values of the registered level and event pulses.
  always_comb begin
    level_d   = (state_d == ST_PRESSED) || (state_d == ST_LONG_HELD) ||
                (state_d == ST_RELEASE_PEND);
    press_d   = (state_q == ST_PRESS_PEND) && accept_c;
    release_d = (state_q == ST_RELEASE_PEND) && accept_c;
    long_d    = long_evt_c;
  end

  // Counter and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stab_q    <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      stab_q    <= stab_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: one debounce_channel per input bit.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned NUM_CH        = DEF_NUM_CH,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned ACTIVE_LOW    = DEF_ACTIVE_LOW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] btn_raw,
  output logic [NUM_CH-1:0] btn_level,
  output logic [NUM_CH-1:0] press_pulse,
  output logic [NUM_CH-1:0] release_pulse,
  output logic [NUM_CH-1:0] long_pulse
);

  // Independent channel instances.
  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .ACTIVE_LOW    (ACTIVE_LOW)
    ) u_ch (
      .clk           (clk),
      .reset_n       (reset_n),
      .btn_raw       (btn_raw[g]),
      .btn_level     (btn_level[g]),
      .press_pulse   (press_pulse[g]),
      .release_pulse (release_pulse[g]),
      .long_pulse    (long_pulse[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: an edge-indexed sample-history model predicts every output cycle.
module tb_button_conditioner;

  localparam int NCH  = 4;
  localparam int S    = 4;
  localparam int L    = 10;
  localparam int MAXE = 8192;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [NCH-1:0] btn_raw, btn_raw_ah;
  logic [NCH-1:0] lvl_a, prs_a, rel_a, lng_a;
  logic [NCH-1:0] lvl_h, prs_h, rel_h, lng_h;

  assign btn_raw_ah = ~btn_raw;

  button_conditioner #(.NUM_CH(NCH), .STABLE_CYCLES(S), .LONG_CYCLES(L), .ACTIVE_LOW(1)) u_dut_al (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw), .btn_level(lvl_a),
    .press_pulse(prs_a), .release_pulse(rel_a), .long_pulse(lng_a));

  button_conditioner #(.NUM_CH(NCH), .STABLE_CYCLES(S), .LONG_CYCLES(L), .ACTIVE_LOW(0)) u_dut_ah (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw_ah), .btn_level(lvl_h),
    .press_pulse(prs_h), .release_pulse(rel_h), .long_pulse(lng_h));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0] level;
    logic [NCH-1:0] press;
    logic [NCH-1:0] rel;
    logic [NCH-1:0] lng;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: pressed samples per edge since reset release.
  bit hist [NCH][MAXE];
  int edge_n;
  bit mlevel [NCH];
  int last_tog [NCH];
  int press_edge [NCH];

  function automatic bit h(int ch, int k);
    if (k <= 0) return 1'b0;
    return hist[ch][k];
  endfunction

  task automatic model_reset();
    edge_n = 0;
    for (int c = 0; c < NCH; c++) begin
      mlevel[c]     = 1'b0;
      last_tog[c]   = -1000;
      press_edge[c] = -1000;
    end
    exp_q.delete();
  endtask

  // Level flips once the last S synchronized samples (all taken after the
  // previous flip) disagree with it; long fires L edges into a press.
  task automatic model_edge(input logic [NCH-1:0] raw_sampled);
    exp_t e;
    bit   prev, all_diff;
    e = '0;
    edge_n++;
    for (int c = 0; c < NCH; c++) begin
      hist[c][edge_n] = ~raw_sampled[c];
      prev = mlevel[c];
      all_diff = 1'b1;
      for (int j = edge_n - S - 1; j <= edge_n - 2; j++)
        if (h(c, j) == mlevel[c]) all_diff = 1'b0;
      if (all_diff && (edge_n - last_tog[c] >= S)) begin
        mlevel[c]   = ~mlevel[c];
        last_tog[c] = edge_n;
        if (mlevel[c]) begin
          e.press[c]    = 1'b1;
          press_edge[c] = edge_n;
        end else begin
          e.rel[c] = 1'b1;
        end
      end
      if (prev && (edge_n - press_edge[c] == L)) e.lng[c] = 1'b1;
      e.level[c] = mlevel[c];
    end
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [4*NCH-1:0] act, input logic [4*NCH-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h (level,press,release,long)", name, $time, act, expv);
    end
  endtask

  // One clock: the edge samples the current raw value, then new raw is driven.
  task automatic step(input logic [NCH-1:0] next_raw);
    @(posedge clk);
    model_edge(btn_raw);
    #1 btn_raw = next_raw;
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("reset_async_al", {lvl_a, prs_a, rel_a, lng_a}, '0);
    check("reset_async_ah", {lvl_h, prs_h, rel_h, lng_h}, '0);
    repeat (cycles) @(posedge clk);
    #2;
    check("reset_hold_al", {lvl_a, prs_a, rel_a, lng_a}, '0);
    reset_n = 1'b1;
    model_reset();
  endtask

  // Monitor: pops one prediction per cycle and compares both polarity builds.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("outputs_al", {lvl_a, prs_a, rel_a, lng_a}, e);
      check("outputs_ah", {lvl_h, prs_h, rel_h, lng_h}, e);
      n_checks++;
      if ((prs_a & rel_a) != '0) begin
        n_fail++;
        $display("FAIL press_release_overlap at %0t: press %b release %b", $time, prs_a, rel_a);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCH-1:0] cur;
    int tmr [NCH];
    reset_n = 1'b0;
    btn_raw = '1;
    model_reset();
    #1;
    check("reset_initial", {lvl_a, prs_a, rel_a, lng_a}, '0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;

    repeat (3) step(4'hF);
    // ch0 long hold
    repeat (20) step(4'hE);
    repeat (10) step(4'hF);
    // ch1 short glitch
    repeat (3) step(4'hD);
    repeat (10) step(4'hF);
    // ch2 press, bounce, release
    repeat (8) step(4'hB);
    for (int i = 0; i < 10; i++) step((i % 2) ? 4'hF : 4'hB);
    repeat (10) step(4'hF);
    // all channels together
    repeat (8) step(4'h0);
    repeat (8) step(4'hF);
    // ch3 held across a reset
    repeat (7) step(4'h7);
    do_reset(3);
    repeat (12) step(4'h7);
    repeat (10) step(4'hF);

    // randomized hold/bounce durations per channel
    cur = btn_raw;
    for (int c = 0; c < NCH; c++) tmr[c] = int'($urandom_range(1, 16));
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset(2);
      for (int c = 0; c < NCH; c++) begin
        if (tmr[c] == 0) begin
          cur[c] = ~cur[c];
          tmr[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                               : int'($urandom_range(4, 16));
        end else begin
          tmr[c]--;
        end
      end
      step(cur);
    end
    repeat (4) step(cur);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d predictions left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
